wb_mux_pipe: RTL and testbench

WB_MUX_PIPE -- requirements
Module: wb_mux_pipe

---
 rtl/wb_pkg.sv | 22 ++
 rtl/wb_src_mux.sv | 25 ++
 rtl/wb_mux_pipe.sv | 127 ++++++++++++
 tb/tb_wb_mux_pipe.sv | 230 +++++++++++++++++++++++
 4 files changed

// File: rtl/wb_pkg.sv
// Shared types for the writeback stage: source-select encoding and the
// hold-buffer FSM states.
package wb_pkg;

  typedef enum logic [1:0] {
    WB_SEL_MEM = 2'b00,
    WB_SEL_ALU = 2'b01,
    WB_SEL_PC4 = 2'b10,
    WB_SEL_MUL = 2'b11
  } wb_sel_e;

  typedef enum logic {
    IDLE = 1'b0,
    HELD = 1'b1
  } wb_state_e;

  // Multiplier results arrive later; every other source completes in one cycle.
  function automatic logic is_deferred(input wb_sel_e sel);
    return (sel == WB_SEL_MUL);
  endfunction

endpackage

// File: rtl/wb_src_mux.sv
// Combinational 3-to-1 selector for the single-cycle writeback sources.
module wb_src_mux
  import wb_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  wb_sel_e          sel,
  input  logic [WIDTH-1:0] dataR,
  input  logic [WIDTH-1:0] alu_out,
  input  logic [WIDTH-1:0] pc_plus_4,
  output logic [WIDTH-1:0] mux_out
);

  // Source select; the multiplier path never goes through this mux
  always_comb begin
    mux_out = {WIDTH{1'b0}};
    case (sel)
      WB_SEL_MEM: mux_out = dataR;
      WB_SEL_ALU: mux_out = alu_out;
      WB_SEL_PC4: mux_out = pc_plus_4;
      default:    mux_out = {WIDTH{1'b0}};
    endcase
  end

endmodule

// File: rtl/wb_mux_pipe.sv
// Registered writeback stage merging single-cycle results with one
// outstanding multiplier result; a one-entry buffer absorbs collisions.
module wb_mux_pipe
  import wb_pkg::*;
#(
  parameter int WIDTH  = 32,
  parameter int ADDR_W = 5
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              in_valid,
  input  logic              reg_write,
  input  logic [1:0]        selectLine,
  input  logic [ADDR_W-1:0] rd_addr,
  input  logic [WIDTH-1:0]  alu_out,
  input  logic [WIDTH-1:0]  dataR,
  input  logic [WIDTH-1:0]  pc_plus_4,
  input  logic              mul_valid,
  input  logic [WIDTH-1:0]  mul_out,
  output logic              stall,
  output logic [WIDTH-1:0]  dataW,
  output logic [ADDR_W-1:0] wb_addr,
  output logic              wb_en,
  output logic              mul_busy
);

  wb_sel_e           sel_s;
  wb_state_e         state_r;
  logic [WIDTH-1:0]  mux_out_s;
  logic [WIDTH-1:0]  hold_data_r;
  logic [ADDR_W-1:0] hold_addr_r;
  logic [ADDR_W-1:0] mul_addr_r;
  logic              mul_busy_r;
  logic              stall_s;
  logic              writing_s;
  logic              new_mul_s;
  logic              new_sc_s;
  logic              mul_done_s;

  assign sel_s = wb_sel_e'(selectLine);

  wb_src_mux #(.WIDTH(WIDTH)) u_src_mux (
    .sel       (sel_s),
    .dataR     (dataR),
    .alu_out   (alu_out),
    .pc_plus_4 (pc_plus_4),
    .mux_out   (mux_out_s)
  );

  // Backpressure: buffer occupied, or a second MUL would overwrite the pending one
  always_comb begin
    stall_s = 1'b0;
    if (state_r == HELD) begin
      stall_s = 1'b1;
    end else begin
      stall_s = mul_busy_r && !mul_valid && in_valid && reg_write &&
                is_deferred(sel_s) && (rd_addr != {ADDR_W{1'b0}});
    end
  end

  assign writing_s  = in_valid && !stall_s && reg_write && (rd_addr != {ADDR_W{1'b0}});
  assign new_mul_s  = writing_s && is_deferred(sel_s);
  assign new_sc_s   = writing_s && !is_deferred(sel_s);
  assign mul_done_s = mul_valid && mul_busy_r;
  assign stall      = stall_s;
  assign mul_busy   = mul_busy_r;

  // Writeback register: multiplier beats buffer beats fresh input
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      dataW   <= {WIDTH{1'b0}};
      wb_addr <= {ADDR_W{1'b0}};
      wb_en   <= 1'b0;
    end else if (mul_done_s) begin
      dataW   <= mul_out;
      wb_addr <= mul_addr_r;
      wb_en   <= 1'b1;
    end else if (state_r == HELD) begin
      dataW   <= hold_data_r;
      wb_addr <= hold_addr_r;
      wb_en   <= 1'b1;
    end else if (new_sc_s) begin
      dataW   <= mux_out_s;
      wb_addr <= rd_addr;
      wb_en   <= 1'b1;
    end else begin
      wb_en   <= 1'b0;
    end
  end

  // Hold buffer FSM; HELD never coincides with mul_busy so it drains in one cycle
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r     <= IDLE;
      hold_data_r <= {WIDTH{1'b0}};
      hold_addr_r <= {ADDR_W{1'b0}};
    end else begin
      case (state_r)
        IDLE: begin
          if (mul_done_s && new_sc_s) begin
            state_r     <= HELD;
            hold_data_r <= mux_out_s;
            hold_addr_r <= rd_addr;
          end else begin
            state_r <= IDLE;
          end
        end
        HELD:    state_r <= IDLE;
        default: state_r <= IDLE;
      endcase
    end
  end

  // Outstanding multiplier tracking; a new issue in the completion cycle re-arms it
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      mul_busy_r <= 1'b0;
      mul_addr_r <= {ADDR_W{1'b0}};
    end else if (new_mul_s) begin
      mul_busy_r <= 1'b1;
      mul_addr_r <= rd_addr;
    end else if (mul_done_s) begin
      mul_busy_r <= 1'b0;
    end
  end

endmodule

// File: tb/tb_wb_mux_pipe.sv
// Self-checking bench for wb_mux_pipe: a queue-based writeback model checked
// every cycle, plus directed vectors with hand-computed expectations.
module tb_wb_mux_pipe;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        in_valid = 1'b0;
  logic        reg_write = 1'b0;
  logic [1:0]  selectLine = 2'b00;
  logic [4:0]  rd_addr = 5'd0;
  logic [31:0] alu_out = 32'h0;
  logic [31:0] dataR = 32'h5555_5555;
  logic [31:0] pc_plus_4 = 32'h0000_0004;
  logic        mul_valid = 1'b0;
  logic [31:0] mul_out = 32'h0;
  logic        stall;
  logic [31:0] dataW;
  logic [4:0]  wb_addr;
  logic        wb_en;
  logic        mul_busy;

  int n_cmp = 0;
  int n_fail = 0;

  wb_mux_pipe #(.WIDTH(32), .ADDR_W(5)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .reg_write(reg_write),
    .selectLine(selectLine), .rd_addr(rd_addr), .alu_out(alu_out),
    .dataR(dataR), .pc_plus_4(pc_plus_4), .mul_valid(mul_valid),
    .mul_out(mul_out), .stall(stall), .dataW(dataW), .wb_addr(wb_addr),
    .wb_en(wb_en), .mul_busy(mul_busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: pending writebacks form a queue; one leaves per clock edge
  typedef struct packed {
    logic [31:0] d;
    logic [4:0]  a;
  } wb_t;

  wb_t         hq[$];
  wb_t         cands[$];
  wb_t         tmp;
  logic [31:0] m_data = 32'h0;
  logic [4:0]  m_addr = 5'd0;
  logic        m_en = 1'b0;
  logic        m_busy = 1'b0;
  logic [4:0]  m_mul_rd = 5'd0;

  function automatic logic m_stall();
    return (hq.size() != 0) ||
           (m_busy && !mul_valid && in_valid && reg_write &&
            selectLine == 2'b11 && rd_addr != 5'd0);
  endfunction

  task automatic model_step();
    logic wr;
    logic [31:0] v;
    if (reset) begin
      m_en = 1'b0; m_data = 32'h0; m_addr = 5'd0; m_busy = 1'b0; m_mul_rd = 5'd0;
      hq.delete();
    end else begin
      wr = in_valid && !m_stall() && reg_write && rd_addr != 5'd0;
      cands.delete();
      if (m_busy && mul_valid) begin
        cands.push_back(wb_t'{mul_out, m_mul_rd});
        m_busy = 1'b0;
      end
      while (hq.size() > 0) cands.push_back(hq.pop_front());
      if (wr && selectLine != 2'b11) begin
        v = (selectLine == 2'b00) ? dataR : (selectLine == 2'b01) ? alu_out : pc_plus_4;
        cands.push_back(wb_t'{v, rd_addr});
      end
      if (wr && selectLine == 2'b11) begin
        m_busy = 1'b1;
        m_mul_rd = rd_addr;
      end
      if (cands.size() > 0) begin
        tmp = cands.pop_front();
        m_data = tmp.d; m_addr = tmp.a; m_en = 1'b1;
      end else begin
        m_en = 1'b0;
      end
      hq = cands;
    end
  endtask

  always @(posedge clk or posedge reset) model_step();

  // Per-cycle comparison against the model, away from the active edge
  always @(negedge clk) begin
    chk("stall", {31'd0, stall}, {31'd0, m_stall()});
    chk("wb_en", {31'd0, wb_en}, {31'd0, m_en});
    chk("dataW", dataW, m_data);
    chk("wb_addr", {27'd0, wb_addr}, {27'd0, m_addr});
    chk("mul_busy", {31'd0, mul_busy}, {31'd0, m_busy});
  end

  task automatic drive(input logic iv, input logic rw, input logic [1:0] sel,
                       input logic [4:0] rd, input logic [31:0] alu,
                       input logic mv, input logic [31:0] mo);
    in_valid = iv; reg_write = rw; selectLine = sel; rd_addr = rd;
    alu_out = alu; mul_valid = mv; mul_out = mo;
  endtask

  task automatic idle();
    drive(1'b0, 1'b0, 2'b00, 5'd0, 32'h0, 1'b0, 32'h0);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_wb(input string name, input logic en, input logic [31:0] d, input logic [4:0] a);
    chk({name, "_en"}, {31'd0, wb_en}, {31'd0, en});
    chk({name, "_data"}, dataW, d);
    chk({name, "_addr"}, {27'd0, wb_addr}, {27'd0, a});
  endtask

  initial begin
    reset = 1'b1;
    idle();
    tick(); tick();
    chk_wb("reset", 1'b0, 32'h0, 5'd0);
    chk("reset_busy", {31'd0, mul_busy}, 32'd0);
    chk("reset_stall", {31'd0, stall}, 32'd0);
    reset = 1'b0;
    tick();

    // Single-cycle sources back to back
    drive(1'b1, 1'b1, 2'b00, 5'd3, 32'hAAAA_AAAA, 1'b0, 32'h0); tick();
    chk_wb("mem", 1'b1, 32'h5555_5555, 5'd3);
    drive(1'b1, 1'b1, 2'b01, 5'd3, 32'hAAAA_AAAA, 1'b0, 32'h0); tick();
    chk_wb("alu", 1'b1, 32'hAAAA_AAAA, 5'd3);
    drive(1'b1, 1'b1, 2'b10, 5'd3, 32'hAAAA_AAAA, 1'b0, 32'h0); tick();
    chk_wb("pc4", 1'b1, 32'h0000_0004, 5'd3);
    idle(); tick();
    chk_wb("idle_hold", 1'b0, 32'h0000_0004, 5'd3);

    // Multiplier issue and completion three cycles later
    drive(1'b1, 1'b1, 2'b11, 5'd7, 32'h0, 1'b0, 32'h0); tick();
    chk_wb("mul_issue", 1'b0, 32'h0000_0004, 5'd3);
    chk("mul_busy1", {31'd0, mul_busy}, 32'd1);
    idle(); tick();
    chk("mul_busy2", {31'd0, mul_busy}, 32'd1);
    tick();
    chk("mul_busy3", {31'd0, mul_busy}, 32'd1);
    drive(1'b0, 1'b0, 2'b00, 5'd0, 32'h0, 1'b1, 32'h1234_5678); tick();
    chk_wb("mul_done", 1'b1, 32'h1234_5678, 5'd7);
    chk("mul_busy_clr", {31'd0, mul_busy}, 32'd0);
    idle(); tick();

    // Collision: ALU result arrives with the multiplier result
    drive(1'b1, 1'b1, 2'b11, 5'd7, 32'h0, 1'b0, 32'h0); tick();
    idle(); tick();
    drive(1'b1, 1'b1, 2'b01, 5'd4, 32'h8765_4321, 1'b1, 32'h0000_0010); #1;
    chk("coll_stall0", {31'd0, stall}, 32'd0);
    tick();
    chk_wb("coll_mul", 1'b1, 32'h0000_0010, 5'd7);
    chk("coll_stall1", {31'd0, stall}, 32'd1);
    idle(); tick();
    chk_wb("coll_held", 1'b1, 32'h8765_4321, 5'd4);
    chk("coll_stall2", {31'd0, stall}, 32'd0);
    tick();
    chk("coll_quiet", {31'd0, wb_en}, 32'd0);

    // Second MUL while busy: stalled until the result strobe
    drive(1'b1, 1'b1, 2'b11, 5'd9, 32'h0, 1'b0, 32'h0); tick();
    drive(1'b1, 1'b1, 2'b11, 5'd10, 32'h0, 1'b0, 32'h0); #1;
    chk("mul2_stall", {31'd0, stall}, 32'd1);
    tick();
    chk("mul2_noen", {31'd0, wb_en}, 32'd0);
    drive(1'b1, 1'b1, 2'b11, 5'd10, 32'h0, 1'b1, 32'h0000_CAFE); #1;
    chk("mul2_go", {31'd0, stall}, 32'd0);
    tick();
    chk_wb("mul2_first", 1'b1, 32'h0000_CAFE, 5'd9);
    chk("mul2_busy", {31'd0, mul_busy}, 32'd1);
    drive(1'b0, 1'b0, 2'b00, 5'd0, 32'h0, 1'b1, 32'h0000_BEEF); tick();
    chk_wb("mul2_second", 1'b1, 32'h0000_BEEF, 5'd10);
    chk("mul2_idle", {31'd0, mul_busy}, 32'd0);

    // Non-writing inputs and stray mul_valid
    drive(1'b1, 1'b1, 2'b01, 5'd0, 32'h1111_1111, 1'b0, 32'h0); tick();
    chk_wb("rd0", 1'b0, 32'h0000_BEEF, 5'd10);
    drive(1'b1, 1'b0, 2'b01, 5'd5, 32'h2222_2222, 1'b0, 32'h0); tick();
    chk_wb("norw", 1'b0, 32'h0000_BEEF, 5'd10);
    drive(1'b1, 1'b0, 2'b11, 5'd5, 32'h0, 1'b0, 32'h0); tick();
    chk("norw_mul", {31'd0, mul_busy}, 32'd0);
    drive(1'b0, 1'b0, 2'b00, 5'd0, 32'h0, 1'b1, 32'h3333_3333); tick();
    chk_wb("stray_mv", 1'b0, 32'h0000_BEEF, 5'd10);

    // Reset while the hold buffer is occupied
    drive(1'b1, 1'b1, 2'b11, 5'd12, 32'h0, 1'b0, 32'h0); tick();
    drive(1'b1, 1'b1, 2'b01, 5'd6, 32'hDEAD_0006, 1'b1, 32'h0000_0077); tick();
    chk_wb("rst_pre", 1'b1, 32'h0000_0077, 5'd12);
    idle(); #1;
    reset = 1'b1; #1;
    chk_wb("rst_held", 1'b0, 32'h0, 5'd0);
    chk("rst_held_stall", {31'd0, stall}, 32'd0);
    tick();
    reset = 1'b0;
    tick();
    chk_wb("rst_held_after", 1'b0, 32'h0, 5'd0);

    // Reset with a multiplier result outstanding
    drive(1'b1, 1'b1, 2'b11, 5'd13, 32'h0, 1'b0, 32'h0); tick();
    idle(); tick();
    chk("rst_busy_pre", {31'd0, mul_busy}, 32'd1);
    reset = 1'b1; #1;
    chk("rst_busy", {31'd0, mul_busy}, 32'd0);
    tick();
    reset = 1'b0;
    drive(1'b0, 1'b0, 2'b00, 5'd0, 32'h0, 1'b1, 32'h0000_0099); tick();
    chk_wb("rst_busy_after", 1'b0, 32'h0, 5'd0);
    idle(); tick(); tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
